// File: rtl/wb_master_bridge_if.sv
// ----------------------------------------------------------------------------
// wb_master_bridge_if
// Wishbone classic bus bundle between one wb_master_bridge and the
// interconnect. Signal names keep the master-side view (_o driven by the
// master, _i driven by the slave).
//   wb_addr_o  AW    cycle address
//   wb_data_o  DW    write data
//   wb_we_o    1     write enable
//   wb_sel_o   DW/8  byte selects
//   wb_stb_o   1     strobe
//   wb_cyc_o   1     cycle
//   wb_data_i  DW    read data from slave
//   wb_ack_i   1     slave acknowledge
//   wb_err_i   1     slave error
// ----------------------------------------------------------------------------
interface wb_master_bridge_if #(
   parameter int DW = 32,
   parameter int AW = 32
);
   logic [AW-1:0]   wb_addr_o;
   logic [DW-1:0]   wb_data_o;
   logic            wb_we_o;
   logic [DW/8-1:0] wb_sel_o;
   logic            wb_stb_o;
   logic            wb_cyc_o;
   logic [DW-1:0]   wb_data_i;
   logic            wb_ack_i;
   logic            wb_err_i;

   modport master (
      output wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
      input  wb_data_i, wb_ack_i, wb_err_i
   );

   modport slave (
      input  wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
      output wb_data_i, wb_ack_i, wb_err_i
   );
endinterface

// File: rtl/wb_master_bridge.sv
// ----------------------------------------------------------------------------
// wb_master_bridge
// Turns one CPU memory request into a single Wishbone classic cycle and
// holds the pipeline (stallreq_o) until the slave acks, errors, or the
// watchdog expires. Completion data/error are shown combinationally in the
// completion cycle; if the pipeline is stalled at that moment they are
// buffered and replayed from HOLD until the stall clears.
//
// Parameters: DW data width (multiple of 8), AW address width, STALL_W stall
// vector width, TIMEOUT watchdog cycles (0 disables). The wb interface
// instance must carry the same DW/AW.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   stall_i         pipeline stall vector
//   flush_i         pipeline flush
//   cpu_ce_i        request valid
//   cpu_addr_i      request address
//   cpu_data_i      write data
//   cpu_we_i        1 = write
//   cpu_sel_i       byte enables
//   cpu_data_o      read data (combinational)
//   cpu_err_o       access failed: bus error or timeout (combinational)
//   stallreq_o      stall request to ctrl (combinational)
//   wb              Wishbone master modport, all outputs registered
// ----------------------------------------------------------------------------
module wb_master_bridge #(
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int STALL_W = 6,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [STALL_W-1:0]  stall_i,
   input  logic                flush_i,
   input  logic                cpu_ce_i,
   input  logic [AW-1:0]       cpu_addr_i,
   input  logic [DW-1:0]       cpu_data_i,
   input  logic                cpu_we_i,
   input  logic [DW/8-1:0]     cpu_sel_i,
   output logic [DW-1:0]       cpu_data_o,
   output logic                cpu_err_o,
   output logic                stallreq_o,
   wb_master_bridge_if.master  wb
);
   localparam int SW = DW / 8;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      HOLD = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   data_q, data_d;
   logic            we_q, we_d;
   logic [SW-1:0]   sel_q, sel_d;
   logic            stb_q, stb_d;     // drives both stb and cyc
   logic [DW-1:0]   rd_buf_q, rd_buf_d;
   logic            err_buf_q, err_buf_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic req, tmo, fail, done, rd_ok;

   assign req   = cpu_ce_i && !flush_i;
   // Watchdog only counts as a failure when the slave is silent this cycle;
   // a late ack landing on the last allowed cycle still completes normally.
   assign tmo   = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))
                  && !wb.wb_ack_i && !wb.wb_err_i;
   assign fail  = wb.wb_err_i || tmo;
   assign done  = wb.wb_ack_i || fail;
   assign rd_ok = !we_q && !fail;

   assign wb.wb_addr_o = addr_q;
   assign wb.wb_data_o = data_q;
   assign wb.wb_we_o   = we_q;
   assign wb.wb_sel_o  = sel_q;
   assign wb.wb_stb_o  = stb_q;
   assign wb.wb_cyc_o  = stb_q;

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         data_q    <= '0;
         we_q      <= 1'b0;
         sel_q     <= '0;
         stb_q     <= 1'b0;
         rd_buf_q  <= '0;
         err_buf_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         stb_q     <= stb_d;
         rd_buf_q  <= rd_buf_d;
         err_buf_q <= err_buf_d;
         cnt_q     <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (req) state_d = BUSY;
         BUSY: begin
            if (done)         state_d = (|stall_i) ? HOLD : IDLE;
            else if (flush_i) state_d = IDLE;
         end
         HOLD: if (flush_i || !(|stall_i)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs and datapath next values
   always_comb begin
      addr_d     = addr_q;
      data_d     = data_q;
      we_d       = we_q;
      sel_d      = sel_q;
      stb_d      = stb_q;
      rd_buf_d   = rd_buf_q;
      err_buf_d  = err_buf_q;
      cnt_d      = cnt_q;
      stallreq_o = 1'b0;
      cpu_data_o = '0;
      cpu_err_o  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               addr_d     = cpu_addr_i;
               data_d     = cpu_data_i;
               we_d       = cpu_we_i;
               sel_d      = cpu_sel_i;
               stb_d      = 1'b1;
               cnt_d      = '0;
               stallreq_o = 1'b1;
            end
         end
         BUSY: begin
            if (done || flush_i) begin
               addr_d = '0;
               data_d = '0;
               we_d   = 1'b0;
               sel_d  = '0;
               stb_d  = 1'b0;
            end
            if (done) begin
               // Completion beats a same-cycle flush: data is still returned.
               rd_buf_d   = rd_ok ? wb.wb_data_i : '0;
               err_buf_d  = fail;
               cpu_data_o = rd_ok ? wb.wb_data_i : '0;
               cpu_err_o  = fail;
            end else if (flush_i) begin
               rd_buf_d   = '0;
               err_buf_d  = 1'b0;
               stallreq_o = 1'b1;
            end else begin
               cnt_d      = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
               stallreq_o = 1'b1;
            end
         end
         HOLD: begin
            cpu_data_o = rd_buf_q;
            cpu_err_o  = err_buf_q;
         end
         default: ;
      endcase
   end
endmodule
